// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: shares one 2x2 complex matrix multiplier among NUM_REQ
// requesters. Request pulses are queued as pending bits. Grants go out in
// round-robin order. The granted operands are muxed onto the multiplier, and
// each result comes back with a per-requester done pulse.
//
// Handshake: req_ready[i] is a one-cycle pulse that queues requester i. The
// requester holds req_a[i]/req_b[i] stable until req_done[i] pulses. The
// arbiter raises multiplier_ready for exactly one cycle per grant. The
// multiplier answers with a one-cycle multiplier_done, and multiplier_result
// is valid in that same cycle. A done pulse seen while idle is ignored.
module multiplier_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_BITS     = 2,
  parameter int NUMERIC_BITS = 37,
  parameter int TIMEOUT_BITS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_ready,
  input  logic signed [NUMERIC_BITS-1:0] req_a [0:NUM_REQ-1][0:1][0:1][0:1],
  input  logic signed [NUMERIC_BITS-1:0] req_b [0:NUM_REQ-1][0:1][0:1][0:1],
  output logic [NUM_REQ-1:0]             req_done,
  output logic signed [NUMERIC_BITS-1:0] result_mtx [0:1][0:1][0:1],
  output logic                           busy,
  output logic [REQ_BITS-1:0]            grant_index,
  output logic signed [NUMERIC_BITS-1:0] multiplier_a [0:1][0:1][0:1],
  output logic signed [NUMERIC_BITS-1:0] multiplier_b [0:1][0:1][0:1],
  output logic                           multiplier_ready,
  input  logic                           multiplier_done,
  input  logic signed [NUMERIC_BITS-1:0] multiplier_result [0:1][0:1][0:1],
  output logic                           protocol_error,
  output logic                           timeout_error,
  output logic [1:0]                     state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [TIMEOUT_BITS-1:0] WD_MAX = '1;

  state_t                  state;
  logic [NUM_REQ-1:0]      pending;
  logic [REQ_BITS-1:0]     last_grant;
  logic [TIMEOUT_BITS-1:0] watchdog;

  logic                    complete;
  logic [NUM_REQ-1:0]      grant_mask;
  logic                    rr_found;
  logic [REQ_BITS-1:0]     rr_sel;
  logic [REQ_BITS-1:0]     rr_idx;
  int                      rr_tmp;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // A done pulse counts in ISSUE as well as in WAIT; in IDLE it is dropped.
  assign complete   = multiplier_done && (state == ISSUE || state == WAIT);
  assign grant_mask = NUM_REQ'(1) << grant_index;

  // Round-robin pick: first pending bit from last_grant+1 upward, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_idx   = '0;
    rr_tmp   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_tmp = (int'(last_grant) + k) % NUM_REQ;
      rr_idx = REQ_BITS'(rr_tmp);
      if (!rr_found && pending[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  // Operand mux always follows grant_index.
  always_comb begin
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        for (int p = 0; p < 2; p++) begin
          multiplier_a[r][c][p] = req_a[grant_index][r][c][p];
          multiplier_b[r][c][p] = req_b[grant_index][r][c][p];
        end
  end

  // Pending bits: a new request wins over a completion clear on the same
  // index. A repeat request for a bit that is already pending is absorbed
  // and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending        <= '0;
      protocol_error <= 1'b0;
    end else begin
      pending <= (pending & ~(complete ? grant_mask : '0)) | req_ready;
      if ((req_ready & pending) != '0)
        protocol_error <= 1'b1;
    end
  end

  // Grant FSM with registered outputs, result capture and a saturating watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      last_grant       <= REQ_BITS'(NUM_REQ - 1);
      grant_index      <= '0;
      req_done         <= '0;
      multiplier_ready <= 1'b0;
      watchdog         <= '0;
      timeout_error    <= 1'b0;
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          for (int p = 0; p < 2; p++)
            result_mtx[r][c][p] <= '0;
    end else begin
      req_done <= '0;
      case (state)
        IDLE: begin
          if (rr_found) begin
            grant_index      <= rr_sel;
            multiplier_ready <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (state == ISSUE) begin
            multiplier_ready <= 1'b0;
            watchdog         <= '0;
          end
          if (complete) begin
            result_mtx <= multiplier_result;
            req_done   <= grant_mask;
            last_grant <= grant_index;
            state      <= IDLE;
          end else if (state == ISSUE) begin
            state <= WAIT;
          end else begin
            if (watchdog != WD_MAX)
              watchdog <= watchdog + 1'b1;
            if (watchdog >= WD_MAX - 1'b1)
              timeout_error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/multiplier_arbiter.md
Name: multiplier_arbiter

Overview:
- Shares one 2x2 complex matrix multiplier among NUM_REQ requesters, for example parallel sequence multiplier lanes searching different sequence subtrees.
- Accepts one-cycle request pulses, queues them as pending bits, and grants in round-robin order.
- Muxes the granted operands onto the multiplier, issues its ready pulse, and returns the result with a per-requester done pulse.
- Also flags protocol errors and multiplier timeouts.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- REQ_BITS, 2, width of a requester index; must satisfy 2**REQ_BITS >= NUM_REQ.
- NUMERIC_BITS, 37, signed width of each matrix element (real/imag).
- TIMEOUT_BITS, 8, width of the watchdog counter; timeout fires at 2**TIMEOUT_BITS-1 cycles.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_ready  input  NUM_REQ  one-cycle request pulse per requester.
- req_a  input  signed [NUMERIC_BITS-1:0] [0:NUM_REQ-1][0:1][0:1][0:1]  left operands; held stable from request until that requester's done.
- req_b  input  same shape as req_a  right operands; same stability rule.
- req_done  output  NUM_REQ  one-cycle done pulse, at most one bit high.
- result_mtx  output  signed [NUMERIC_BITS-1:0] [0:1][0:1][0:1]  registered result; valid when any req_done bit is high; held until the next completion.
- busy  output  1  high whenever state != IDLE.
- grant_index  output  REQ_BITS  requester currently or last granted.
- multiplier_a  output  signed [NUMERIC_BITS-1:0] [0:1][0:1][0:1]  equals req_a[grant_index] (combinational mux).
- multiplier_b  output  same shape  equals req_b[grant_index].
- multiplier_ready  output  1  one-cycle start pulse to the multiplier.
- multiplier_done  input  1  multiplier completion pulse.
- multiplier_result  input  same shape as result_mtx  multiplier output, valid with multiplier_done.
- protocol_error  output  1  sticky; set when req_ready arrives for an index that is already pending.
- timeout_error  output  1  sticky; set when the watchdog expires.

Behaviour:
- Reset: pending=0, state=IDLE, last_grant=NUM_REQ-1, grant_index=0, req_done=0, multiplier_ready=0, result_mtx=0, busy=0, watchdog=0, both error flags=0.
- Reset mid-operation discards everything. A multiplier_done arriving while in IDLE is ignored.
- Pending register: req_ready[i] sets pending[i] at the clock edge where it is sampled. pending[i] clears on the edge that issues req_done[i].
  - If set and clear hit the same index in the same cycle, set wins.
  - req_ready[i] while pending[i]=1 sets protocol_error; the request is absorbed, not queued twice.
- State machine:
  - IDLE: if pending != 0, select the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap. Latch it into grant_index, set multiplier_ready<=1, go to ISSUE. Pending bits set in this same cycle are not considered until the next cycle.
  - ISSUE: lasts exactly one cycle, during which multiplier_ready is high. Set multiplier_ready<=0, clear watchdog, go to WAIT.
  - WAIT: hold grant_index and increment watchdog.
    - On multiplier_done: result_mtx<=multiplier_result, req_done[grant_index]<=1 for one cycle, clear pending[grant_index], last_grant<=grant_index, go to IDLE.
    - If watchdog reaches all-ones before done: set timeout_error and keep waiting; the watchdog saturates.
    - A multiplier_done in the ISSUE cycle is treated as arriving in WAIT (accepted).
- Latency: a request sampled at edge E0 into an idle arbiter gives multiplier_ready high in the cycle after E1. With a multiplier taking L cycles from its ready to its done, req_done is high L+1 cycles after multiplier_ready.
- Back-to-back: the IDLE cycle after a completion may grant again, so one dead cycle between grants is the minimum.
- Fairness: a continuously re-requesting requester cannot be granted twice while another is pending.
- Operand mux follows grant_index at all times. Operands are meaningful only from ISSUE through done.

Test Plan:
- Bench multiplier model: returns multiplier_a after 3 cycles. Requester i drives req_a[i][0][0][0] = i+1.
- Single request: reset, pulse req_ready=4'b0100 -> multiplier_ready high once; 4 cycles later req_done=4'b0100 and result_mtx[0][0][0]=3; busy low afterward.
- Simultaneous requests: pulse 4'b1111 in one cycle -> grants in order 0,1,2,3 with done tags 1,2,3,4. Exactly one multiplier_ready per grant; no overlapping busy periods.
- Round robin after wrap: complete requester 2, then pulse 4'b0101 -> requester 0 is granted before 2 (scan starts at 3, wraps to 0). last_grant=3 afterward is not required.
- Duplicate request: pulse req_ready[1] twice while pending -> protocol_error=1 (sticky through later traffic); only one req_done[1].
- Timeout and reset: model never asserts done -> timeout_error after 255 WAIT cycles, busy stays 1. Assert reset -> all outputs return to reset values. A late done pulse then produces no req_done.
